// File: rtl/vgafb_gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_gray_pkg
// Description : Shared FSM state type and Gray/binary conversion helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package vgafb_gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vgafb_gray_decode.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_gray_decode
// Description : Purely combinational Gray-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module vgafb_gray_decode #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic [COUNTER_WIDTH-1:0] i_gray,
    output logic [COUNTER_WIDTH-1:0] o_bin
);

    // Running XOR from the MSB down: b[i] = b[i+1] ^ g[i].
    always_comb begin
        logic w_acc;
        w_acc = 1'b0;
        o_bin = '0;
        for (int i = COUNTER_WIDTH - 1; i >= 0; i--) begin
            w_acc    = w_acc ^ i_gray[i];
            o_bin[i] = w_acc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vgafb_graysync.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_graysync
// Description : Gray-count CDC synchronizer with binary decode, fill level and
//               optional illegal-transition detector (VGAFB_GRAYSYNC_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module vgafb_graysync
    import vgafb_gray_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_in,
    input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
    input  logic [COUNTER_WIDTH-1:0] LocalCount_in,
    input  logic                     Clear_in,
    output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
    output logic [COUNTER_WIDTH-1:0] Level_out,
    output logic                     Valid_out,
    output logic                     Error_out
);

    localparam int                   c_cnt_w    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(SYNC_STAGES);

    logic [COUNTER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [COUNTER_WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [COUNTER_WIDTH-1:0] bin_q, bin_d;
    logic [COUNTER_WIDTH-1:0] level_q, level_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] w_sync_last;
    logic [COUNTER_WIDTH-1:0] w_dec_bin;

    assign w_sync_last = sync_q[SYNC_STAGES-1];

    vgafb_gray_decode #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_decode (
        .i_gray(w_sync_last),
        .o_bin (w_dec_bin)
    );

    always_comb begin
        sync_d[0] = Clear_in ? '0 : GrayCount_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = Clear_in ? '0 : sync_q[i-1];
        end
        bin_d   = Clear_in ? '0 : w_dec_bin;
        level_d = Clear_in ? '0 : (w_dec_bin - LocalCount_in);
    end

    // The IDLE->FILL edge already clocks fresh data into a zeroed chain, so it
    // counts as the first warm-up edge; after Clear the count starts at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (Clear_in) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    cnt_d   = c_cnt_one;
                end
                FILL: begin
                    if (cnt_q == c_cnt_last) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_q   <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            bin_q   <= bin_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign BinaryCount_out = bin_q;
    assign Level_out       = level_q;
    assign Valid_out       = (state_q == RUN);

`ifdef VGAFB_GRAYSYNC_CHECK_EN
    localparam logic [COUNTER_WIDTH-1:0] c_cw_one = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] prev_q, prev_d;
    logic [COUNTER_WIDTH-1:0] w_diff;
    logic                     w_multi;
    logic                     err_q, err_d;

    // More than one set bit in the XOR means an illegal Gray step.
    always_comb begin
        w_diff  = w_sync_last ^ prev_q;
        w_multi = |(w_diff & (w_diff - c_cw_one));
        prev_d  = Clear_in ? '0 : w_sync_last;
        err_d   = Clear_in ? 1'b0 : (err_q | ((state_q == RUN) && w_multi));
    end

    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign Error_out = err_q;
`else
    assign Error_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vgafb_graysync.sv
`default_nettype none
// ============================================================================
// Module      : tb_vgafb_graysync
// Description : Directed scoreboard bench for vgafb_graysync (W=4, 2 stages).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vgafb_graysync;

`ifdef VGAFB_GRAYSYNC_CHECK_EN
    localparam logic C_ERR = 1'b1;
`else
    localparam logic C_ERR = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_in;
    logic [3:0] GrayCount_in;
    logic [3:0] LocalCount_in;
    logic       Clear_in;
    logic [3:0] BinaryCount_out;
    logic [3:0] Level_out;
    logic       Valid_out;
    logic       Error_out;

    vgafb_graysync #(
        .COUNTER_WIDTH(4),
        .SYNC_STAGES  (2)
    ) dut (
        .Clk            (Clk),
        .Reset_in       (Reset_in),
        .GrayCount_in   (GrayCount_in),
        .LocalCount_in  (LocalCount_in),
        .Clear_in       (Clear_in),
        .BinaryCount_out(BinaryCount_out),
        .Level_out      (Level_out),
        .Valid_out      (Valid_out),
        .Error_out      (Error_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [3:0] bin;
        logic [3:0] lvl;
        logic       vld;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [3:0] b, input logic [3:0] l,
                        input logic v, input logic e);
        exp_t x;
        x.tag = tag; x.bin = b; x.lvl = l; x.vld = v; x.err = e;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty got=%0d required=1", sb.size());
        end else begin
            x = sb.pop_front();
            checks++;
            assert (BinaryCount_out === x.bin) else begin
                errors++;
                $error("FAIL %s bin got=%b required=%b", x.tag, BinaryCount_out, x.bin);
            end
            checks++;
            assert (Level_out === x.lvl) else begin
                errors++;
                $error("FAIL %s level got=%b required=%b", x.tag, Level_out, x.lvl);
            end
            checks++;
            assert (Valid_out === x.vld) else begin
                errors++;
                $error("FAIL %s valid got=%b required=%b", x.tag, Valid_out, x.vld);
            end
            checks++;
            assert (Error_out === x.err) else begin
                errors++;
                $error("FAIL %s error got=%b required=%b", x.tag, Error_out, x.err);
            end
        end
    endtask

    // One clock: queue the expectation, let the edge happen, compare just after it.
    task automatic step(input string tag, input logic [3:0] b, input logic [3:0] l,
                        input logic v, input logic e);
        push(tag, b, l, v, e);
        @(posedge Clk);
        #1;
        pop_check();
    endtask

    initial begin
        Reset_in      = 1'b1;
        Clear_in      = 1'b0;
        GrayCount_in  = 4'b0000;
        LocalCount_in = 4'b0000;
        repeat (2) @(posedge Clk);
        #1;
        push("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b0);
        pop_check();

        // Latency: stable 0110 / 0001, released between edges
        GrayCount_in  = 4'b0110;
        LocalCount_in = 4'b0001;
        #2 Reset_in = 1'b0;
        step("lat_e1",   4'b0000, 4'b1111, 1'b0, 1'b0);
        step("lat_e2",   4'b0000, 4'b1111, 1'b0, 1'b0);
        step("lat_e3",   4'b0100, 4'b0011, 1'b1, 1'b0);
        step("lat_hold", 4'b0100, 4'b0011, 1'b1, 1'b0);

        // Legal single-bit step to Gray 0111 (binary 5)
        GrayCount_in = 4'b0111;
        step("step_e1", 4'b0100, 4'b0011, 1'b1, 1'b0);
        step("step_e2", 4'b0100, 4'b0011, 1'b1, 1'b0);
        step("step_e3", 4'b0101, 4'b0100, 1'b1, 1'b0);

        // Clear for one cycle while BinaryCount_out=0101
        Clear_in = 1'b1;
        step("clr_edge", 4'b0000, 4'b0000, 1'b0, 1'b0);
        Clear_in = 1'b0;
        step("clr_f1", 4'b0000, 4'b1111, 1'b0, 1'b0);
        step("clr_f2", 4'b0000, 4'b1111, 1'b0, 1'b0);
        step("clr_f3", 4'b0101, 4'b0100, 1'b1, 1'b0);

        // Wrap: local 1110, Gray 1000 then 0000
        Clear_in      = 1'b1;
        GrayCount_in  = 4'b1000;
        LocalCount_in = 4'b1110;
        step("wrap_clr", 4'b0000, 4'b0000, 1'b0, 1'b0);
        Clear_in = 1'b0;
        step("wrap_f1",  4'b0000, 4'b0010, 1'b0, 1'b0);
        step("wrap_f2",  4'b0000, 4'b0010, 1'b0, 1'b0);
        step("wrap_max", 4'b1111, 4'b0001, 1'b1, 1'b0);
        GrayCount_in = 4'b0000;
        step("wrap_h1",   4'b1111, 4'b0001, 1'b1, 1'b0);
        step("wrap_h2",   4'b1111, 4'b0001, 1'b1, 1'b0);
        step("wrap_zero", 4'b0000, 4'b0010, 1'b1, 1'b0);

        // Illegal two-bit step 0000 -> 0011 in RUN
        GrayCount_in = 4'b0011;
        step("err_e1",  4'b0000, 4'b0010, 1'b1, 1'b0);
        step("err_e2",  4'b0000, 4'b0010, 1'b1, 1'b0);
        step("err_set", 4'b0010, 4'b0100, 1'b1, C_ERR);
        for (int i = 0; i < 10; i++) begin
            step("err_hold", 4'b0010, 4'b0100, 1'b1, C_ERR);
        end
        GrayCount_in = 4'b0010;
        step("err_dec_e1", 4'b0010, 4'b0100, 1'b1, C_ERR);
        step("err_dec_e2", 4'b0010, 4'b0100, 1'b1, C_ERR);
        step("err_dec_e3", 4'b0011, 4'b0101, 1'b1, C_ERR);

        // Asynchronous reset between edges, then release
        #2 Reset_in = 1'b1;
        #1;
        push("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        pop_check();
        step("rst_held", 4'b0000, 4'b0000, 1'b0, 1'b0);
        #2 Reset_in = 1'b0;
        step("rel_e1", 4'b0000, 4'b0010, 1'b0, 1'b0);
        step("rel_e2", 4'b0000, 4'b0010, 1'b0, 1'b0);
        step("rel_e3", 4'b0011, 4'b0101, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
